// File: rtl/acc_cpu_if.sv
// Instruction-fetch bus between the accumulator core and its instruction source.
// The core drives pc/instr_ready and the source answers with instr/instr_valid.
interface acc_cpu_if #(
    parameter int PCW = 8
);
    logic [7:0]     instr;
    logic           instr_valid;
    logic           instr_ready;
    logic [PCW-1:0] pc;

    modport master (
        input  instr,
        input  instr_valid,
        output instr_ready,
        output pc
    );

    modport slave (
        output instr,
        output instr_valid,
        input  instr_ready,
        input  pc
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/DECODE/EXECUTE/HALT controller, register file, ALU, PC.
// Optional feature macro ACC_CPU_SHIFT_EN enables opcode 14 as a one-bit shift.
module acc_cpu_core #(
    parameter int DW    = 8,
    parameter int NREGS = 16,
    parameter int PCW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    acc_cpu_if.master     fetch,
    output logic [DW-1:0] acc,
    output logic          zero,
    output logic          carry,
    output logic          halted
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LDI   = 4'd1;
    localparam logic [3:0] OP_LDR   = 4'd2;
    localparam logic [3:0] OP_STR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_JMP   = 4'd11;
    localparam logic [3:0] OP_JZ    = 4'd12;
    localparam logic [3:0] OP_JC    = 4'd13;
    localparam logic [3:0] OP_SHIFT = 4'd14;
    localparam logic [3:0] OP_HLT   = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [7:0]      r_ir;
    logic [DW-1:0]   r_opnd;
    logic [DW-1:0]   r_acc;
    logic            r_carry;
    logic [PCW-1:0]  r_pc;
    logic            r_ready;
    logic            r_halted;
    logic [DW-1:0]   r_regs [NREGS];

    logic [3:0]      w_op;
    logic [IDXW-1:0] w_idx;
    logic            w_idx_ok;
    logic [DW-1:0]   w_imm_dw;
    logic [PCW-1:0]  w_imm_pc;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic [DW:0]     w_inc;
    logic [DW:0]     w_dec;
    logic [DW-1:0]   w_acc_next;
    logic            w_carry_next;
    logic [PCW-1:0]  w_pc_next;
    logic            w_reg_we;
    logic            w_halt;

    assign w_op     = r_ir[7:4];
    assign w_idx    = r_ir[IDXW-1:0];
    assign w_idx_ok = (int'(w_idx) < NREGS);
    assign w_imm_dw = DW'(r_ir[3:0]);
    assign w_imm_pc = PCW'(r_ir[3:0]);

    // Bit DW of each extended result is carry-out (add/inc) or borrow (sub/dec).
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_opnd};
    assign w_diff = {1'b0, r_acc} - {1'b0, r_opnd};
    assign w_inc  = {1'b0, r_acc} + (DW+1)'(1);
    assign w_dec  = {1'b0, r_acc} - (DW+1)'(1);

    always_comb begin
        w_acc_next   = r_acc;
        w_carry_next = r_carry;
        w_pc_next    = r_pc + PCW'(1);
        w_reg_we     = 1'b0;
        w_halt       = 1'b0;
        case (w_op)
            OP_NOP: ;
            OP_LDI: w_acc_next = w_imm_dw;
            OP_LDR: w_acc_next = r_opnd;
            OP_STR: w_reg_we   = w_idx_ok;
            OP_ADD: begin
                w_acc_next   = w_sum[DW-1:0];
                w_carry_next = w_sum[DW];
            end
            OP_SUB: begin
                w_acc_next   = w_diff[DW-1:0];
                w_carry_next = w_diff[DW];
            end
            OP_AND: w_acc_next = r_acc & r_opnd;
            OP_OR:  w_acc_next = r_acc | r_opnd;
            OP_XOR: w_acc_next = r_acc ^ r_opnd;
            OP_INC: begin
                w_acc_next   = w_inc[DW-1:0];
                w_carry_next = w_inc[DW];
            end
            OP_DEC: begin
                w_acc_next   = w_dec[DW-1:0];
                w_carry_next = w_dec[DW];
            end
            OP_JMP: w_pc_next = w_imm_pc;
            OP_JZ:  if (r_acc == '0) w_pc_next = w_imm_pc;
            OP_JC:  if (r_carry) w_pc_next = w_imm_pc;
            OP_SHIFT: begin
`ifdef ACC_CPU_SHIFT_EN
                if (r_ir[0]) begin
                    w_acc_next   = {1'b0, r_acc[DW-1:1]};
                    w_carry_next = r_acc[0];
                end else begin
                    w_acc_next   = {r_acc[DW-2:0], 1'b0};
                    w_carry_next = r_acc[DW-1];
                end
`else
                w_acc_next   = r_acc;
                w_carry_next = r_carry;
`endif
            end
            OP_HLT: begin
                w_pc_next = r_pc;
                w_halt    = 1'b1;
            end
            default: ;
        endcase
    end

    // r_ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_pc     <= '0;
            r_ready  <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_ready && fetch.instr_valid) begin
                        r_ir    <= fetch.instr;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_opnd  <= w_idx_ok ? r_regs[w_idx] : '0;
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    r_pc    <= w_pc_next;
                    if (w_reg_we) begin
                        r_regs[w_idx] <= r_acc;
                    end
                    if (w_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_ready  <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                        r_ready <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_ready  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign fetch.instr_ready = r_ready;
    assign fetch.pc          = r_pc;
    assign acc               = r_acc;
    assign zero              = (r_acc == '0);
    assign carry             = r_carry;
    assign halted            = r_halted;
endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: table-driven program with a scoreboard queue,
// plus hand sequences for latency, halt, reset mid-execute and shift behaviour.
module tb_acc_cpu_core;
    logic       clk;
    logic       reset;
    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic       halted;

    acc_cpu_if #(.PCW(8)) bus ();

    acc_cpu_core #(.DW(8), .NREGS(16), .PCW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .fetch  (bus),
        .acc    (acc),
        .zero   (zero),
        .carry  (carry),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ins;
        logic [7:0] e_acc;
        logic       e_c;
        logic [7:0] e_pc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    vec_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", {31'd0, bus.instr_ready}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Issue one instruction and compare architectural state once the core returns to FETCH.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] e_acc,
                             input logic e_c, input logic [7:0] e_pc);
        int   waited;
        int   lat;
        vec_t e;
        waited = 0;
        while (!bus.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("fetch_ready", {31'd0, bus.instr_ready}, 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        e.ins = ins; e.e_acc = e_acc; e.e_c = e_c; e.e_pc = e_pc;
        sb.push_back(e);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = ~ins;
        lat = 1;
        while (!bus.instr_ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        e = sb.pop_front();
        chk("acc", {24'd0, acc}, {24'd0, e.e_acc});
        chk("carry", {31'd0, carry}, {31'd0, e.e_c});
        chk("pc", {24'd0, bus.pc}, {24'd0, e.e_pc});
        $display("[TB] instr %02h -> acc %02h carry %0d pc %0d (expected %02h %0d %0d)",
                 e.ins, acc, carry, bus.pc, e.e_acc, e.e_c, e.e_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] sh;
        logic [7:0] m_acc;
        logic       m_c;

        vecs[0]  = '{8'h19, 8'h09, 1'b0, 8'd1};
        vecs[1]  = '{8'h31, 8'h09, 1'b0, 8'd2};
        vecs[2]  = '{8'h17, 8'h07, 1'b0, 8'd3};
        vecs[3]  = '{8'h41, 8'h10, 1'b0, 8'd4};
        vecs[4]  = '{8'h10, 8'h00, 1'b0, 8'd5};
        vecs[5]  = '{8'hA0, 8'hFF, 1'b1, 8'd6};
        vecs[6]  = '{8'hD9, 8'hFF, 1'b1, 8'd9};
        vecs[7]  = '{8'h11, 8'h01, 1'b1, 8'd10};
        vecs[8]  = '{8'hC2, 8'h01, 1'b1, 8'd11};
        vecs[9]  = '{8'h51, 8'hF8, 1'b1, 8'd12};
        vecs[10] = '{8'h33, 8'hF8, 1'b1, 8'd13};
        vecs[11] = '{8'h1C, 8'h0C, 1'b1, 8'd14};
        vecs[12] = '{8'h63, 8'h08, 1'b1, 8'd15};
        vecs[13] = '{8'h71, 8'h09, 1'b1, 8'd16};
        vecs[14] = '{8'h83, 8'hF1, 1'b1, 8'd17};
        vecs[15] = '{8'h90, 8'hF2, 1'b0, 8'd18};
        vecs[16] = '{8'h21, 8'h09, 1'b0, 8'd19};
        vecs[17] = '{8'h00, 8'h09, 1'b0, 8'd20};
        vecs[18] = '{8'hB3, 8'h09, 1'b0, 8'd3};
        vecs[19] = '{8'h10, 8'h00, 1'b0, 8'd4};
        vecs[20] = '{8'hC7, 8'h00, 1'b0, 8'd7};
        vecs[21] = '{8'hA0, 8'hFF, 1'b1, 8'd8};
        vecs[22] = '{8'h90, 8'h00, 1'b1, 8'd9};
        vecs[23] = '{8'h23, 8'hF8, 1'b1, 8'd10};
        vecs[24] = '{8'h43, 8'hF0, 1'b1, 8'd11};
        vecs[25] = '{8'h51, 8'hE7, 1'b0, 8'd12};
        vecs[26] = '{8'hD5, 8'hE7, 1'b0, 8'd13};

        reset           = 1'b1;
        bus.instr       = 8'h00;
        bus.instr_valid = 1'b0;

        // Reset and stall
        do_reset();
        chk("rst_pc", {24'd0, bus.pc}, 32'd0);
        chk("rst_acc", {24'd0, acc}, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_zero", {31'd0, zero}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i].ins, vecs[i].e_acc, vecs[i].e_c, vecs[i].e_pc);
        end

        // ADD latency: acc holds through DECODE, updates after the commit edge
        bus.instr       = 8'h41;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h1F;
        chk("add_lat_e0", {24'd0, acc}, 32'hE7);
        @(negedge clk);
        chk("add_lat_e1", {24'd0, acc}, 32'hE7);
        @(negedge clk);
        chk("add_lat_e2", {24'd0, acc}, 32'hF0);
        chk("add_lat_pc", {24'd0, bus.pc}, 32'd14);
        chk("add_lat_ready", {31'd0, bus.instr_ready}, 32'd1);
        $display("[TB] instr 41 (latency) -> acc %02h pc %0d", acc, bus.pc);

        // Shift sequence
        run_instr(8'h19, 8'h09, 1'b0, 8'd15);
        m_acc = 8'h09;
        m_c   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
`ifdef ACC_CPU_SHIFT_EN
            sh    = {m_acc, 1'b0};
            m_acc = sh[7:0];
            m_c   = sh[8];
`endif
            run_instr(8'hE0, m_acc, m_c, 8'(15 + k));
        end
`ifdef ACC_CPU_SHIFT_EN
        run_instr(8'hE1, 8'h10, 1'b0, 8'd21);
`else
        run_instr(8'hE1, 8'h09, 1'b0, 8'd21);
`endif

        // Halt at pc 3 with instr_valid held high
        do_reset();
        run_instr(8'hB3, 8'h00, 1'b0, 8'd3);
        bus.instr       = 8'hF0;
        bus.instr_valid = 1'b1;
        repeat (3) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_ready", {31'd0, bus.instr_ready}, 32'd0);
            chk("halt_pc", {24'd0, bus.pc}, 32'd3);
        end
        $display("[TB] instr f0 -> halted %0d pc %0d", halted, bus.pc);
        do_reset();
        chk("halt_rst_pc", {24'd0, bus.pc}, 32'd0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);

        // Reset asserted during the EXECUTE cycle of ADD R2
        run_instr(8'h15, 8'h05, 1'b0, 8'd1);
        run_instr(8'h32, 8'h05, 1'b0, 8'd2);
        bus.instr       = 8'h42;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_acc", {24'd0, acc}, 32'd0);
        chk("midrst_pc", {24'd0, bus.pc}, 32'd0);
        chk("midrst_ready", {31'd0, bus.instr_ready}, 32'd0);
        $display("[TB] reset mid-execute -> acc %02h pc %0d", acc, bus.pc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_acc_after", {24'd0, acc}, 32'd0);
        run_instr(8'h22, 8'h00, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
